// File: rtl/if_pc_gen_if.sv
// Fetch-PC generator bus: redirect requests and stall in, fetch PC, flush and pending status out.
// With IF_PC_ALIGN_CHK_EN defined the bus also carries Addr_Err.
interface if_pc_gen_if #(
    parameter int ADDR_W = 32
);
    logic              Stall_IF;
    logic              Exc_Req;
    logic              Branch_Taken_MEM;
    logic [ADDR_W-1:0] Branch_Dest_MEM;
    logic              Jump_Control_ID;
    logic [ADDR_W-1:0] Jump_Dest_ID;
    logic [ADDR_W-1:0] PC_IF;
    logic [ADDR_W-1:0] PC_Plus_Inc_IF;
    logic              Flush_IF;
    logic              Redirect_Pend;
`ifdef IF_PC_ALIGN_CHK_EN
    logic              Addr_Err;
`endif

    modport master (
        output Stall_IF, Exc_Req, Branch_Taken_MEM, Branch_Dest_MEM,
               Jump_Control_ID, Jump_Dest_ID,
        input  PC_IF, PC_Plus_Inc_IF, Flush_IF, Redirect_Pend
`ifdef IF_PC_ALIGN_CHK_EN
       ,input  Addr_Err
`endif
    );

    modport slave (
        input  Stall_IF, Exc_Req, Branch_Taken_MEM, Branch_Dest_MEM,
               Jump_Control_ID, Jump_Dest_ID,
        output PC_IF, PC_Plus_Inc_IF, Flush_IF, Redirect_Pend
`ifdef IF_PC_ALIGN_CHK_EN
       ,output Addr_Err
`endif
    );
endinterface

// File: rtl/if_pc_gen.sv
// IF-stage registered PC generator with exception/branch/jump/sequential selection and a stall redirect buffer.
// Optional target alignment check enabled by defining IF_PC_ALIGN_CHK_EN.
module if_pc_gen #(
    parameter int                ADDR_W    = 32,
    parameter int                INC       = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h0000_0180)
) (
    input  logic          Clk,
    input  logic          Reset,
    if_pc_gen_if.slave    bus
);

    localparam logic [ADDR_W-1:0] INC_W = ADDR_W'(INC);

    typedef enum logic {IDLE, PEND} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic              pend_exc_q, pend_exc_d;
`ifdef IF_PC_ALIGN_CHK_EN
    logic              addr_err_q, addr_err_d;
    logic              misaligned;
`endif

    logic              live;
    logic              apply;
    logic [ADDR_W-1:0] live_tgt;
    logic [ADDR_W-1:0] raw_tgt;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] pc_plus_inc;

    assign live        = bus.Exc_Req | bus.Branch_Taken_MEM | bus.Jump_Control_ID;
    assign apply       = !bus.Stall_IF && (live || state_q == PEND);
    assign pc_plus_inc = pc_q + INC_W;

    // Live target is what gets buffered; raw target also weighs the buffer when it is released.
    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        live_tgt = bus.Jump_Dest_ID;
        if (bus.Exc_Req)               live_tgt = EXC_VEC;
        else if (bus.Branch_Taken_MEM) live_tgt = bus.Branch_Dest_MEM;

        raw_tgt = pend_pc_q;
        if (bus.Exc_Req)                          raw_tgt = EXC_VEC;
        else if (state_q == PEND && pend_exc_q)   raw_tgt = EXC_VEC;
        else if (bus.Branch_Taken_MEM)            raw_tgt = bus.Branch_Dest_MEM;
        else if (bus.Jump_Control_ID)             raw_tgt = bus.Jump_Dest_ID;
    end

`ifdef IF_PC_ALIGN_CHK_EN
    assign misaligned  = |raw_tgt[1:0];
    assign redirect_pc = misaligned ? EXC_VEC : raw_tgt;
`else
    assign redirect_pc = raw_tgt;
`endif

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_VEC;
            pend_pc_q  <= '0;
            pend_exc_q <= 1'b0;
`ifdef IF_PC_ALIGN_CHK_EN
            addr_err_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_pc_q  <= pend_pc_d;
            pend_exc_q <= pend_exc_d;
`ifdef IF_PC_ALIGN_CHK_EN
            addr_err_q <= addr_err_d;
`endif
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        pend_exc_d = pend_exc_q;
`ifdef IF_PC_ALIGN_CHK_EN
        addr_err_d = apply && misaligned;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.Stall_IF) begin
                    if (live) begin
                        pend_pc_d  = live_tgt;
                        pend_exc_d = bus.Exc_Req;
                        state_d    = PEND;
                    end
                end else begin
                    pc_d = live ? redirect_pc : pc_plus_inc;
                end
            end
            PEND: begin
                if (bus.Stall_IF) begin
                    // A buffered exception may only be displaced by a newer exception.
                    if (live && (!pend_exc_q || bus.Exc_Req)) begin
                        pend_pc_d  = live_tgt;
                        pend_exc_d = bus.Exc_Req;
                    end
                end else begin
                    pc_d       = redirect_pc;
                    pend_exc_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.PC_IF          = pc_q;
        bus.PC_Plus_Inc_IF = pc_plus_inc;
        bus.Flush_IF       = !Reset && apply;
        bus.Redirect_Pend  = (state_q == PEND);
`ifdef IF_PC_ALIGN_CHK_EN
        bus.Addr_Err       = addr_err_q;
`endif
    end

endmodule

// File: doc/if_pc_gen.md
Name: if_pc_gen

Overview:
Registered program-counter generator for the IF stage, and successor to the combinational next-PC select. It holds the architectural fetch PC and selects the next PC from exception, branch, jump or sequential sources under a fixed priority. It honours the fetch stall, and buffers a redirect that arrives during a stall so that it is never lost. It drives the fetch address and the IF/ID flush.

Parameters:
ADDR_W, 32, PC width in bits
INC, 4, sequential increment in bytes
RESET_VEC, 32'h0000_0000, PC value loaded on reset
EXC_VEC, 32'h0000_0180, exception handler target

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
Stall_IF  in  1  hold the PC; from the hazard unit
Exc_Req  in  1  exception redirect request
Branch_Taken_MEM  in  1  taken-branch redirect
Branch_Dest_MEM  in  ADDR_W  branch target
Jump_Control_ID  in  1  jump redirect
Jump_Dest_ID  in  ADDR_W  jump target
PC_IF  out  ADDR_W  current fetch address (registered)
PC_Plus_Inc_IF  out  ADDR_W  PC_IF + INC, combinational, modulo 2^ADDR_W
Flush_IF  out  1  kill the instruction in IF/ID, combinational
Redirect_Pend  out  1  a buffered redirect is waiting (registered)

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-high. While Reset=1:
  - PC_IF=RESET_VEC
  - pending buffer cleared: Pend_Valid=0, Pend_Exc=0, Pend_PC=0
  - Redirect_Pend=0, Flush_IF=0
  - first fetch after release is at RESET_VEC
- Source priority: Exc_Req > Branch_Taken_MEM > Jump_Control_ID > pending buffer > sequential.
  - Branch beats jump because the MEM instruction is older.
- Pending exception rule: a pending exception (Pend_Exc=1) outranks a live branch or jump, but never a live Exc_Req; EXC_VEC is the same either way.
- Live redirect (Live): any of Exc_Req, Branch_Taken_MEM or Jump_Control_ID is high. Target (Tgt) is the winning live source's target.
- FSM states:
  - IDLE: Pend_Valid=0
  - PEND: Pend_Valid=1
- IDLE, Stall_IF=0:
  - Live: PC_IF<=Tgt, Flush_IF=1
  - otherwise: PC_IF<=PC_IF+INC, Flush_IF=0
- IDLE, Stall_IF=1:
  - PC_IF holds.
  - Live: Pend_PC<=Tgt, Pend_Exc<=Exc_Req, go to PEND, Flush_IF=0.
- PEND, Stall_IF=1:
  - PC_IF holds.
  - Live and Pend_Exc=0: overwrite Pend_PC and Pend_Exc with the live request.
  - Live and Pend_Exc=1: overwrite only if Exc_Req=1.
- PEND, Stall_IF=0:
  - PC_IF<=winner of {live, pending} per the priority rule, Flush_IF=1.
  - Clear Pend_Valid and Pend_Exc; return to IDLE.
- Redirect_Pend=Pend_Valid.
- Latency:
  - a redirect accepted in cycle N appears on PC_IF in cycle N+1
  - a stalled redirect appears one cycle after Stall_IF falls
- Wrap-around: increment is modulo 2^ADDR_W; PC=2^ADDR_W-INC steps to 0 with no flag.
- Reset mid-stall or mid-PEND: pending buffer discarded, PC_IF=RESET_VEC.

Optional Feature:
Macro: IF_PC_ALIGN_CHK_EN
- Defined:
  - Extra output Addr_Err (1 bit, registered, reset 0).
  - A selected redirect target with Tgt[1:0]!=0 is replaced by EXC_VEC.
  - Addr_Err pulses 1 for exactly one cycle, concurrent with PC_IF=EXC_VEC.
  - The check also applies when a pending target is applied.
- Undefined: no Addr_Err port. Targets load unmodified.

Test Plan:
- Reset release, no redirects, 4 clocks -> PC_IF=0x0,0x4,0x8,0xC; Flush_IF=0 throughout.
- PC_IF=0x100, Branch_Taken_MEM=1 with Dest=0x400 and Jump_Control_ID=1 with Dest=0x800 in the same cycle -> next PC_IF=0x400, Flush_IF=1 that cycle.
- PC_IF=0x20, Stall_IF=1 for 3 cycles, Jump_Dest_ID=0x600 pulsed in stall cycle 1 -> PC_IF holds 0x20, Redirect_Pend=1; the cycle after the stall drops PC_IF=0x600, Flush_IF=1 in the release cycle, Redirect_Pend=0.
- During the stall, Exc_Req pulses, then a branch to 0x900 arrives -> after release PC_IF=0x180; the branch is discarded.
- PC_IF=0xFFFF_FFFC, no redirect -> next PC_IF=0x0000_0000.
- Reset asserted asynchronously mid-PEND with Pend_PC=0x600 -> PC_IF=RESET_VEC immediately, Redirect_Pend=0.
- Macro defined only: jump to 0x402 -> PC_IF=0x180, Addr_Err=1 for one cycle.
